// File: rtl/aes_pkg.sv
// Shared definitions for the AES MixColumns datapath: widths, FSM state type and GF(2^8) helpers.
// Latency: n/a (package, combinational helper functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  // Inverse coefficients are built from the x2/x4/x8 chain only, no generic multiplier.
  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// One AES column through MixColumns (02,03,01,01) or InvMixColumns (0e,0b,0d,09).
// Latency: combinational, no registers.
// Backpressure: none, pure function of its inputs.
// Ports: col_in  - column, byte 0 in bits [31:24]
//        inv     - 1 selects the inverse transform
//        col_out - transformed column, same byte order
module aes_mixcol_col
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_in,
  input  logic                 inv,
  output logic [AES_COL_W-1:0] col_out
);

  logic [7:0] w_s [4];

  for (genvar b = 0; b < 4; b++) begin : g_split
    assign w_s[b] = col_in[AES_COL_W-1-8*b -: 8];
  end

  // Output row r sees the coefficient vector rotated by r across s0..s3.
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] w_fwd;
    logic [7:0] w_inv;
    assign w_fwd = gf_mul2(w_s[r]) ^ gf_mul3(w_s[(r+1)%4]) ^
                   w_s[(r+2)%4] ^ w_s[(r+3)%4];
    assign w_inv = gf_mule(w_s[r]) ^ gf_mulb(w_s[(r+1)%4]) ^
                   gf_muld(w_s[(r+2)%4]) ^ gf_mul9(w_s[(r+3)%4]);
    assign col_out[AES_COL_W-1-8*r -: 8] = inv ? w_inv : w_fwd;
  end

endmodule

// File: rtl/aes_mixcol_seq.sv
// Sequenced MixColumns / InvMixColumns / bypass over a 128-bit AES state, NCOL columns per cycle.
// Latency: accept edge T -> out_valid after edge T+4/NCOL; block period is 4/NCOL+2 with out_ready held high.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so one block in flight.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data/in_inv/in_bypass input handshake;
//        out_valid/out_ready/out_data output handshake; busy = not IDLE.
//        Byte 0 of the state is in_data[127:120]; column c is bytes 4c..4c+3.
module aes_mixcol_seq
  import aes_pkg::*;
#(
  parameter int NCOL   = 1,
  parameter bit INV_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  input  logic                   in_inv,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  if (!(NCOL == 1 || NCOL == 2 || NCOL == 4)) begin : g_bad_ncol
    $error("aes_mixcol_seq: NCOL must be 1, 2 or 4");
  end

  localparam int NSTEPS = 4 / NCOL;

  aes_state_e             r_state;
  logic [1:0]             r_cnt;
  logic                   r_inv;
  logic                   r_bypass;
  logic [AES_STATE_W-1:0] r_in;
  logic [AES_COL_W-1:0]   r_res [4];

  logic [AES_COL_W-1:0]   w_cols    [4];
  logic [1:0]             w_idx     [NCOL];
  logic [AES_COL_W-1:0]   w_col_in  [NCOL];
  logic [AES_COL_W-1:0]   w_col_mix [NCOL];
  logic [AES_COL_W-1:0]   w_col_res [NCOL];

  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign w_cols[c] = r_in[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
  end

  // Lane j handles column cnt*NCOL+j; with NCOL=4 the counter stays at 0.
  for (genvar j = 0; j < NCOL; j++) begin : g_lane
    assign w_idx[j]    = 2'(int'(r_cnt) * NCOL + j);
    assign w_col_in[j] = w_cols[w_idx[j]];

    aes_mixcol_col u_col (
      .col_in  (w_col_in[j]),
      .inv     (r_inv),
      .col_out (w_col_mix[j])
    );

    assign w_col_res[j] = r_bypass ? w_col_in[j] : w_col_mix[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_inv    <= 1'b0;
      r_bypass <= 1'b0;
      r_in     <= '0;
      for (int c = 0; c < 4; c++) r_res[c] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in     <= in_data;
            r_inv    <= in_inv & INV_EN;
            r_bypass <= in_bypass;
            r_cnt    <= '0;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int j = 0; j < NCOL; j++) r_res[w_idx[j]] <= w_col_res[j];
          if (r_cnt == 2'(NSTEPS - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = {r_res[0], r_res[1], r_res[2], r_res[3]};

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Bench for aes_mixcol_seq: four instances (NCOL 1/2/4 with inverse, NCOL 1 without inverse).
// Latency: n/a.
// Backpressure: bench drives out_ready, holding it low for the stall scenario.
module tb_aes_mixcol_seq;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] DB4      = {4{32'hdb135345}};
  localparam logic [127:0] MC4      = {4{32'h8e4da1bc}};
  localparam logic [127:0] MIX_IN   = 128'hdb135345f20a225cd4d4d4d52d26314c;
  localparam logic [127:0] MIX_OUT  = 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8;
  localparam logic [127:0] FIXPT    = 128'h01010101c6c6c6c6c6c6c6c601010101;
  localparam logic [127:0] BYP      = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  logic         tb_rst       [4];
  logic         tb_in_valid  [4];
  logic         tb_in_ready  [4];
  logic [127:0] tb_in_data   [4];
  logic         tb_in_inv    [4];
  logic         tb_in_bypass [4];
  logic         tb_out_valid [4];
  logic         tb_out_ready [4];
  logic [127:0] tb_out_data  [4];
  logic         tb_busy      [4];

  logic [127:0] exp_q [4][$];
  int           acc_cyc [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int k, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %h expected %h", k, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NC  = (g == 1) ? 2 : (g == 2) ? 4 : 1;
    localparam int LAT = 4 / NC;

    aes_mixcol_seq #(
      .NCOL   (NC),
      .INV_EN ((g == 3) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk       (clk),
      .rst       (tb_rst[g]),
      .in_valid  (tb_in_valid[g]),
      .in_ready  (tb_in_ready[g]),
      .in_data   (tb_in_data[g]),
      .in_inv    (tb_in_inv[g]),
      .in_bypass (tb_in_bypass[g]),
      .out_valid (tb_out_valid[g]),
      .out_ready (tb_out_ready[g]),
      .out_data  (tb_out_data[g]),
      .busy      (tb_busy[g])
    );

    // Monitor: compares every presented output against the queue head, pops on handshake.
    bit prev_v = 1'b0;
    always @(negedge clk) begin
      if (tb_rst[g]) begin
        prev_v = 1'b0;
      end else begin
        if (tb_out_valid[g]) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL inst%0d unexpected_out: got %h expected no output", g, tb_out_data[g]);
          end else begin
            chk(g, "out_data", tb_out_data[g], exp_q[g][0]);
          end
          if (!prev_v) chk(g, "latency", 128'(cyc - acc_cyc[g]), 128'(LAT));
          chk(g, "in_ready_in_done", 128'(tb_in_ready[g]), 128'd0);
          chk(g, "busy_in_done", 128'(tb_busy[g]), 128'd1);
          if (tb_out_ready[g] && exp_q[g].size() > 0) void'(exp_q[g].pop_front());
        end
        prev_v = tb_out_valid[g];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one block, wait for acceptance, then scramble the inputs to show the captured copy is used.
  task automatic send(input int k, input logic [127:0] d, input logic inv, input logic byp,
                      input logic [127:0] exp);
    int n;
    tb_in_data[k]   = d;
    tb_in_inv[k]    = inv;
    tb_in_bypass[k] = byp;
    tb_in_valid[k]  = 1'b1;
    n = 0;
    while (!tb_in_ready[k] && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL inst%0d accept_timeout: got in_ready=0 expected 1", k);
      tb_in_valid[k] = 1'b0;
    end else begin
      exp_q[k].push_back(exp);
      tick();
      acc_cyc[k]      = cyc;
      tb_in_valid[k]  = 1'b0;
      tb_in_data[k]   = ~d;
      tb_in_inv[k]    = ~inv;
      tb_in_bypass[k] = ~byp;
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0 || tb_busy[k]) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL inst%0d drain_timeout: got %0d pending expected 0", k, exp_q[k].size());
      exp_q[k].delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int raise_cyc;
    for (int k = 0; k < 4; k++) begin
      tb_rst[k]       = 1'b1;
      tb_in_valid[k]  = 1'b0;
      tb_in_data[k]   = '0;
      tb_in_inv[k]    = 1'b0;
      tb_in_bypass[k] = 1'b0;
      tb_out_ready[k] = 1'b1;
      acc_cyc[k]      = 0;
    end
    #12;
    for (int k = 0; k < 4; k++) begin
      chk(k, "rst_out_valid", 128'(tb_out_valid[k]), 128'd0);
      chk(k, "rst_in_ready", 128'(tb_in_ready[k]), 128'd1);
      chk(k, "rst_busy", 128'(tb_busy[k]), 128'd0);
      chk(k, "rst_out_data", tb_out_data[k], 128'd0);
    end
    tick();
    for (int k = 0; k < 4; k++) tb_rst[k] = 1'b0;
    tick();

    // Forward, replicated column.
    send(0, DB4, 1'b0, 1'b0, MC4);
    wait_idle(0);

    // FIPS-197 round 1 forward and inverse at every column width.
    for (int k = 0; k < 3; k++) begin
      send(k, FIPS_IN, 1'b0, 1'b0, FIPS_OUT);
      wait_idle(k);
      send(k, FIPS_OUT, 1'b1, 1'b0, FIPS_IN);
      wait_idle(k);
      send(k, MIX_IN, 1'b0, 1'b0, MIX_OUT);
      wait_idle(k);
    end
    send(1, MIX_OUT, 1'b1, 1'b0, MIX_IN);
    wait_idle(1);

    // Inverse not built: in_inv is ignored.
    send(3, DB4, 1'b1, 1'b0, MC4);
    wait_idle(3);
    send(3, FIPS_IN, 1'b1, 1'b0, FIPS_OUT);
    wait_idle(3);

    // Bypass overrides in_inv.
    send(0, BYP, 1'b1, 1'b1, BYP);
    wait_idle(0);
    send(2, BYP, 1'b1, 1'b1, BYP);
    wait_idle(2);

    // Fixed-point columns, both directions.
    send(0, FIXPT, 1'b0, 1'b0, FIXPT);
    wait_idle(0);
    send(1, FIXPT, 1'b1, 1'b0, FIXPT);
    wait_idle(1);

    // Back-to-back with out_ready held high.
    send(0, FIPS_IN, 1'b0, 1'b0, FIPS_OUT);
    send(0, DB4, 1'b0, 1'b0, MC4);
    wait_idle(0);

    // Backpressure: stall 10 cycles in DONE with a new block already offered.
    tb_out_ready[0] = 1'b0;
    send(0, FIPS_IN, 1'b0, 1'b0, FIPS_OUT);
    n = 0;
    while (!tb_out_valid[0] && n < 50) begin
      tick();
      n++;
    end
    tb_in_data[0]   = DB4;
    tb_in_inv[0]    = 1'b0;
    tb_in_bypass[0] = 1'b0;
    tb_in_valid[0]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk(0, "stall_out_valid", 128'(tb_out_valid[0]), 128'd1);
      chk(0, "stall_in_ready", 128'(tb_in_ready[0]), 128'd0);
    end
    tb_out_ready[0] = 1'b1;
    raise_cyc = cyc;
    send(0, DB4, 1'b0, 1'b0, MC4);
    chk(0, "accept_after_handshake", 128'(acc_cyc[0] - raise_cyc), 128'd2);
    wait_idle(0);

    // Asynchronous reset two columns into BUSY, then a clean transaction.
    send(0, DB4, 1'b0, 1'b0, MC4);
    tick();
    tick();
    tb_rst[0] = 1'b1;
    #1;
    chk(0, "midrst_out_valid", 128'(tb_out_valid[0]), 128'd0);
    chk(0, "midrst_in_ready", 128'(tb_in_ready[0]), 128'd1);
    chk(0, "midrst_busy", 128'(tb_busy[0]), 128'd0);
    chk(0, "midrst_out_data", tb_out_data[0], 128'd0);
    void'(exp_q[0].pop_back());
    #1;
    tb_rst[0] = 1'b0;
    tick();
    send(0, DB4, 1'b0, 1'b0, MC4);
    wait_idle(0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
